fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the MIPS pipeline; produces the speculative PC stream and feeds the IF/ID register.
- Presents the PC to instruction memory. Memory is combinational, so the instruction returns in the same cycle.
- Statically predicts control flow: j/jal and beq/bne are predicted taken; jr falls through.
- Consumes the one-cycle redirect pair (normal, rpc) from the decode-side frontend check. On a redirect it squashes the wrong-path instruction and restarts at rpc.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- normal  in  1  0 = redirect this cycle (mispredict/jr)
- rpc  in  32  redirect target, valid when normal=0
- imem_addr  out  32  fetch address (= pc)
- imem_instr  in  32  instruction at imem_addr, same cycle
- d_ready  in  1  decode accepts the IF/ID entry
- f_valid  out  1  IF/ID entry valid
- f_pc  out  32  PC of the IF/ID instruction
- f_instr  out  32  IF/ID instruction
- f_pred_taken  out  1  fetch predicted a redirect of flow
- redirect_cnt  out  CNT_W  number of redirects taken, saturating

Behaviour:
- Reset (asynchronous, resetn=0):
  - pc=RESET_PC, state=BOOT.
  - f_valid=0, f_pc=0, f_instr=0, f_pred_taken=0, redirect_cnt=0.
- State machine:
  - BOOT: one cycle after reset release. No fetch is captured and f_valid stays 0. Always goes to RUN.
  - RUN: normal operation.
  - A reassertion of resetn=0 in any state returns immediately to BOOT with reset values.
- Next-PC prediction, combinational from pc and imem_instr:
  - opcode 000100/000101 (beq/bne): pc+4+(sext(imm16)<<2), pred=1.
  - opcode 000010/000011 (j/jal): {pc_plus4[31:28], instr[25:0], 2'b00}, pred=1.
  - All other opcodes, including jr: pc+4, pred=0.
  - All PC arithmetic is modulo 2^32; wrap-around is silent.
- Advance condition in RUN: adv = !f_valid || d_ready.
- Priority in RUN, highest first:
  1. Redirect (normal=0): pc<=rpc; f_valid<=0 (wrong-path entry squashed); redirect_cnt+=1, saturating at all-ones. This overrides stall and any pending d_ready.
  2. adv=1: f_valid<=1, f_pc<=pc, f_instr<=imem_instr, f_pred_taken<=pred, pc<=next_pc.
  3. Otherwise (stall): all registers hold, and imem_addr stays stable.
- A redirect arriving during BOOT is ignored. The frontend cannot produce one with an empty pipe.
- Latency:
  - The instruction at pc appears on f_* the next edge after it is fetched with adv=1.
  - After a redirect, the instruction at rpc appears on f_* two edges after the redirect cycle, leaving one bubble.
- A redirect whose rpc equals the current pc is legal. It costs one bubble with no functional effect.
- Back-to-back redirects are each honoured; the last one wins.

Optional Feature:
- Macro: FETCH_RAS_EN.
- Defined:
  - Adds a 4-entry circular return-address stack.
  - jal pushes pc+4. When full, the oldest entry is overwritten.
  - jr with rs=31 predicts the top of stack, pops it, and sets pred=1.
  - jr with an empty stack predicts pc+4 with pred=0.
  - Stack pointer and entries reset to 0.
  - The stack is not repaired on redirect. The frontend still always redirects jr, so a correct prediction costs one bubble and a wrong one is harmless.
- Not defined: no stack exists; jr always predicts pc+4 with pred=0.

Decomposition:
- Shared package fetch_pkg holds:
  - opcode constants OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_SPECIAL, FUNCT_JR;
  - the state enum {BOOT, RUN};
  - RAS_DEPTH=4.
- One natural sub-module: fetch_predict, a combinational next_pc/pred generator taking pc, instr and the RAS top. It is reusable by the verification model.

Test Plan:
1. Reset, then release with d_ready=1 and imem returning NOPs. Required: f_valid=0 in the BOOT cycle; then f_pc=0, 4, 8 on consecutive cycles.
2. pc=0x100, instr=beq with imm=0x0003. Required: next f_pc=0x100 with f_pred_taken=1, then f_pc=0x110.
3. Redirect (normal=0, rpc=0x200) while d_ready=0 and f_valid=1. Required: f_valid=0 next cycle, f_pc=0x200 the following cycle, redirect_cnt=1.
4. Hold d_ready=0 for 3 cycles with f_valid=1. Required: f_pc, f_instr and imem_addr unchanged; pc advances on the first cycle d_ready=1.
5. pc=0x0FFF_FFFC, instr=j with index 0x000_0010. Required: next pc=0x1000_0040 (upper bits taken from pc+4). pc=0xFFFF_FFFC with a NOP: next pc wraps to 0.
6. With FETCH_RAS_EN: jal at 0x40, then jr $31. Required: jr predicted to 0x44 with pred=1. Assert resetn=0 mid-stream: all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: opcode constants,
// the fetch state enum and return-address-stack sizing.
package fetch_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    localparam int RAS_DEPTH = 4;
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_predict.sv
// Combinational static next-PC predictor: branches and direct jumps are
// predicted taken, jr $31 uses the return-address-stack top when one is
// supplied and valid, everything else falls through to pc+4.
module fetch_predict
    import fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_ras_top,
    input  logic        i_ras_valid,
    output logic [31:0] o_next_pc,
    output logic        o_pred,
    output logic        o_is_jal,
    output logic        o_is_ret
);

    logic [5:0]  w_op;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_op        = i_instr[31:26];
    assign w_pc_plus4  = i_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
    assign w_j_target  = {w_pc_plus4[31:28], i_instr[25:0], 2'b00};

    assign o_is_jal = (w_op == OP_JAL);
    assign o_is_ret = (w_op == OP_SPECIAL) && (i_instr[5:0] == FUNCT_JR)
                      && (i_instr[25:21] == 5'd31);

    // Select the predicted next PC and whether flow was redirected.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        o_next_pc = w_pc_plus4;
        o_pred    = 1'b0;
        if ((w_op == OP_BEQ) || (w_op == OP_BNE)) begin
            o_next_pc = w_br_target;
            o_pred    = 1'b1;
        end else if ((w_op == OP_J) || (w_op == OP_JAL)) begin
            o_next_pc = w_j_target;
            o_pred    = 1'b1;
        end else if (o_is_ret && i_ras_valid) begin
            o_next_pc = i_ras_top;
            o_pred    = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: drives the PC to a combinational instruction memory,
// captures the IF/ID entry, follows static predictions and restarts at rpc
// when the decode-side check signals a redirect (normal=0).
// Optional build macro FETCH_RAS_EN adds a 4-entry return-address stack
// used to predict jr $31.
module fetch_pc_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             normal,
    input  logic [31:0]      rpc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             d_ready,
    output logic             f_valid,
    output logic [31:0]      f_pc,
    output logic [31:0]      f_instr,
    output logic             f_pred_taken,
    output logic [CNT_W-1:0] redirect_cnt
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [31:0]      r_pc;
    logic             r_f_valid;
    logic [31:0]      r_f_pc;
    logic [31:0]      r_f_instr;
    logic             r_f_pred;
    logic [CNT_W-1:0] r_cnt;

    logic             w_adv;
    logic             w_do_redirect;
    logic             w_do_fetch;
    logic [31:0]      w_next_pc;
    logic             w_pred;
    logic             w_is_jal;
    logic             w_is_ret;
    logic [31:0]      w_ras_top;
    logic             w_ras_valid;

    fetch_predict u_predict (
        .i_pc        (r_pc),
        .i_instr     (imem_instr),
        .i_ras_top   (w_ras_top),
        .i_ras_valid (w_ras_valid),
        .o_next_pc   (w_next_pc),
        .o_pred      (w_pred),
        .o_is_jal    (w_is_jal),
        .o_is_ret    (w_is_ret)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: non-blocking (<=) in clocked blocks so every register sees pre-edge values.
        if (!resetn) r_state <= BOOT;
        else         r_state <= w_state_next;
    end

    // Next state: BOOT lasts exactly one cycle, RUN is terminal until reset.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BOOT:    w_state_next = RUN;
            RUN:     w_state_next = RUN;
            default: w_state_next = BOOT;
        endcase
    end

    assign w_adv = !r_f_valid || d_ready;

    // State outputs: redirect beats advance; nothing happens during BOOT.
    always_comb begin
        w_do_redirect = 1'b0;
        w_do_fetch    = 1'b0;
        if (r_state == RUN) begin
            if (!normal)    w_do_redirect = 1'b1;
            else if (w_adv) w_do_fetch    = 1'b1;
        end
    end

    // PC and IF/ID entry; a redirect squashes the entry, a stall holds all.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_f_valid <= 1'b0;
            r_f_pc    <= 32'h0;
            r_f_instr <= 32'h0;
            r_f_pred  <= 1'b0;
        end else if (w_do_redirect) begin
            r_pc      <= rpc;
            r_f_valid <= 1'b0;
        end else if (w_do_fetch) begin
            r_f_valid <= 1'b1;
            r_f_pc    <= r_pc;
            r_f_instr <= imem_instr;
            r_f_pred  <= w_pred;
            r_pc      <= w_next_pc;
        end
    end

    // Saturating count of redirects taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                         r_cnt <= '0;
        else if (w_do_redirect && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end

`ifdef FETCH_RAS_EN
    logic [31:0]          r_ras [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] r_ras_sp;   // next slot to write
    logic [RAS_PTR_W:0]   r_ras_cnt;  // live entries, capped at RAS_DEPTH
    logic [RAS_PTR_W-1:0] w_ras_top_idx;

    assign w_ras_top_idx = r_ras_sp - RAS_PTR_W'(1);
    assign w_ras_top     = r_ras[w_ras_top_idx];
    assign w_ras_valid   = (r_ras_cnt != '0);

    // Circular return-address stack: jal pushes, predicted jr $31 pops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ras_sp  <= '0;
            r_ras_cnt <= '0;
            // NOTE: entries are reset explicitly; the stack is tiny, and a defined top keeps predictions reproducible.
            for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= 32'h0;
        end else if (w_do_fetch) begin
            if (w_is_jal) begin
                r_ras[r_ras_sp] <= r_pc + 32'd4;
                r_ras_sp        <= r_ras_sp + RAS_PTR_W'(1);
                if (r_ras_cnt != (RAS_PTR_W + 1)'(RAS_DEPTH))
                    r_ras_cnt <= r_ras_cnt + (RAS_PTR_W + 1)'(1);
            end else if (w_is_ret && w_ras_valid) begin
                r_ras_sp  <= w_ras_top_idx;
                r_ras_cnt <= r_ras_cnt - (RAS_PTR_W + 1)'(1);
            end
        end
    end
`else
    logic w_unused_ras;

    assign w_ras_top    = 32'h0;
    assign w_ras_valid  = 1'b0;
    assign w_unused_ras = w_is_jal | w_is_ret;
`endif

    assign imem_addr    = r_pc;
    assign f_valid      = r_f_valid;
    assign f_pc         = r_f_pc;
    assign f_instr      = r_f_instr;
    assign f_pred_taken = r_f_pred;
    assign redirect_cnt = r_cnt;

endmodule
